// File: rtl/rx_pkg.sv
// Shared types and sizing for the receive FIFO controller.
// Optional packet discard on error/overrun is enabled with RX_ERR_DISCARD_EN.
package rx_pkg;

    localparam int RX_FIFO_DEPTH = 8;
    localparam int RX_PTR_W      = 4;
    localparam int RX_DATA_W     = 8;
    localparam int RX_ADDR_W     = $clog2(RX_FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RCV    = 2'd1,
        COMMIT = 2'd2,
        DROP   = 2'd3
    } rx_state_e;

    // Pointers carry one extra wrap bit, so plain modulo-16 increment is enough.
    function automatic logic [RX_PTR_W-1:0] ptrInc(input logic [RX_PTR_W-1:0] ptr);
        return ptr + RX_PTR_W'(1);
    endfunction

endpackage

// File: rtl/rx_fifo_mem.sv
// 8x8 register file backing the receive FIFO: synchronous write, asynchronous read.
// Storage is intentionally not reset; the pointers alone define what is valid.
module rx_fifo_mem
    import rx_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [RX_ADDR_W-1:0] waddr_i,
    input  logic [RX_DATA_W-1:0] wdata_i,
    input  logic [RX_ADDR_W-1:0] raddr_i,
    output logic [RX_DATA_W-1:0] rdata_o
);

    logic [RX_DATA_W-1:0] mem_q [RX_FIFO_DEPTH];

    // Capture an accepted byte at the write address on the rising edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO controller: bytes of a packet are written speculatively and only
// become visible to the reader once the whole packet commits.
// Defining RX_ERR_DISCARD_EN rolls back packets that ended with an error or overrun.
module rx_fifo_ctrl
    import rx_pkg::*;
(
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rcving,
    input  logic                 w_enable,
    input  logic                 r_error,
    input  logic [RX_DATA_W-1:0] rcv_data,
    input  logic                 r_enable,
    output logic [RX_DATA_W-1:0] r_data,
    output logic                 empty,
    output logic                 full,
    output logic                 pkt_done,
    output logic                 pkt_drop,
    output logic                 overrun
);

    rx_state_e           state_q, state_d;
    logic [RX_PTR_W-1:0] wptr_q, wptr_d;
    logic [RX_PTR_W-1:0] cptr_q, cptr_d;
    logic [RX_PTR_W-1:0] rptr_q, rptr_d;
    logic                overrun_q, overrun_d;

    logic                fullInt;
    logic                emptyInt;
    logic                wrAccept;
    logic                wrLost;
    logic                popAccept;
    logic                dropReq;

    assign emptyInt  = (rptr_q == cptr_q);
    assign fullInt   = (wptr_q[RX_ADDR_W-1:0] == rptr_q[RX_ADDR_W-1:0]) &&
                       (wptr_q[RX_PTR_W-1] != rptr_q[RX_PTR_W-1]);
    assign wrAccept  = (state_q == RCV) && w_enable && !fullInt;
    assign wrLost    = (state_q == RCV) && w_enable && fullInt;
    assign popAccept = r_enable && !emptyInt;

`ifdef RX_ERR_DISCARD_EN
    assign dropReq = r_error | overrun_q | wrLost;
`else
    logic unusedErr;
    assign unusedErr = r_error;
    assign dropReq   = 1'b0;
`endif

    rx_fifo_mem u_mem (
        .clk_i   (clk),
        .we_i    (wrAccept),
        .waddr_i (wptr_q[RX_ADDR_W-1:0]),
        .wdata_i (rcv_data),
        .raddr_i (rptr_q[RX_ADDR_W-1:0]),
        .rdata_o (r_data)
    );

    // Packet state register, forced back to IDLE immediately on reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Packet sequencing: receive, then one cycle of commit or rollback.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (rcving) state_d = RCV;
            RCV:    if (!rcving) state_d = dropReq ? DROP : COMMIT;
            COMMIT: state_d = rcving ? RCV : IDLE;
            DROP:   state_d = rcving ? RCV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packet outcome pulses follow directly from the current state.
    always_comb begin
        pkt_done = (state_q == COMMIT);
`ifdef RX_ERR_DISCARD_EN
        pkt_drop = (state_q == DROP);
`else
        pkt_drop = 1'b0;
`endif
    end

    // Next pointer and overrun values; a fresh packet starts with overrun clear.
    always_comb begin
        wptr_d    = wptr_q;
        cptr_d    = cptr_q;
        rptr_d    = rptr_q;
        overrun_d = overrun_q;
        if (wrAccept) begin
            wptr_d = ptrInc(wptr_q);
        end
        if (wrLost) begin
            overrun_d = 1'b1;
        end
        if (state_q == COMMIT) begin
            cptr_d = wptr_q;
        end
        if (state_q == DROP) begin
            wptr_d = cptr_q;
        end
        if (popAccept) begin
            rptr_d = ptrInc(rptr_q);
        end
        if ((state_q != RCV) && (state_d == RCV)) begin
            overrun_d = 1'b0;
        end
    end

    // Pointer and overrun registers; reset empties the FIFO including pending bytes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q    <= '0;
            cptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            cptr_q    <= cptr_d;
            rptr_q    <= rptr_d;
            overrun_q <= overrun_d;
        end
    end

    assign empty   = emptyInt;
    assign full    = fullInt;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_rx_fifo_ctrl.sv
// Testbench for rx_fifo_ctrl, behaviour follows RX_ERR_DISCARD_EN when defined.
// Model: a queue of committed unread bytes plus a queue of pending packet bytes.
module tb_rx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic [7:0] rcv_data;
    logic       r_enable;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       pkt_done;
    logic       pkt_drop;
    logic       overrun;

    int         compared   = 0;
    int         mismatched = 0;

    logic [7:0] expQ[$];
    logic [7:0] pendQ[$];
    bit         modelOverrun = 1'b0;
    bit         modelDone    = 1'b0;
    bit         modelDrop    = 1'b0;
    bit         monitorOn    = 1'b0;
    bit         forceRead    = 1'b0;
    int         popPct       = 0;

    rx_fifo_ctrl dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rcving   (rcving),
        .w_enable (w_enable),
        .r_error  (r_error),
        .rcv_data (rcv_data),
        .r_enable (r_enable),
        .r_data   (r_data),
        .empty    (empty),
        .full     (full),
        .pkt_done (pkt_done),
        .pkt_drop (pkt_drop),
        .overrun  (overrun)
    );

    // Free-running clock, roughly the 96 MHz system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compare flags each cycle and pop the scoreboard whenever the DUT accepts a read.
    always @(negedge clk) begin
        if (n_rst && monitorOn) begin
            checkOutput("empty", empty, expQ.size() == 0);
            checkOutput("full", full, (expQ.size() + pendQ.size()) >= 8);
            checkOutput("pkt_done", pkt_done, modelDone);
            checkOutput("pkt_drop", pkt_drop, modelDrop);
            checkOutput("overrun", overrun, modelOverrun);
            if (r_enable && !empty) begin
                if (expQ.size() == 0) begin
                    checkOutput("r_data_unexpected_pop", 32'd1, 32'd0);
                end else begin
                    checkOutput("r_data", r_data, expQ.pop_front());
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit rcv, input bit we, input logic [7:0] data, input bit err);
        rcving   = rcv;
        w_enable = we;
        rcv_data = data;
        r_error  = err;
        r_enable = forceRead ? 1'b1 : ($urandom_range(0, 99) < popPct);
        tick();
    endtask

    task automatic startPacket();
        applyStimulus(1'b1, 1'($urandom), 8'($urandom), 1'($urandom));
        modelOverrun = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit lost;
        lost = (expQ.size() + pendQ.size()) >= 8;
        applyStimulus(1'b1, 1'b1, b, 1'($urandom));
        if (lost) modelOverrun = 1'b1;
        else      pendQ.push_back(b);
    endtask

    task automatic gapCycle();
        applyStimulus(1'b1, 1'b0, 8'($urandom), 1'($urandom));
    endtask

    task automatic endPacket(input bit err, input bit nextRcv);
        bit commit;
`ifdef RX_ERR_DISCARD_EN
        commit = !(err || modelOverrun);
`else
        commit = 1'b1;
`endif
        applyStimulus(1'b0, 1'b0, 8'($urandom), err);
        modelDone = commit;
        modelDrop = !commit;
        applyStimulus(nextRcv, 1'b0, 8'($urandom), 1'($urandom));
        modelDone = 1'b0;
        modelDrop = 1'b0;
        if (commit) begin
            foreach (pendQ[i]) expQ.push_back(pendQ[i]);
        end
        pendQ.delete();
        if (nextRcv) modelOverrun = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'($urandom), 8'($urandom), 1'($urandom));
        end
    endtask

    task automatic sendPacket(input logic [7:0] bytes[$], input bit err);
        startPacket();
        foreach (bytes[i]) sendByte(bytes[i]);
        endPacket(err, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        forceRead = 1'b1;
        while (expQ.size() != 0 && budget < 20) begin
            idleCycles(1);
            budget++;
        end
        forceRead = 1'b0;
        if (expQ.size() != 0) checkOutput("drain_timeout", expQ.size(), 0);
        idleCycles(1);
    endtask

    // Directed scenarios first, then randomized packets with random pops.
    initial begin
        logic [7:0] pkt[$];
        bit inPkt;
        n_rst    = 1'b0;
        rcving   = 1'b0;
        w_enable = 1'b0;
        r_error  = 1'b0;
        rcv_data = 8'h00;
        r_enable = 1'b0;
        #1;
        checkOutput("reset_empty", empty, 1);
        checkOutput("reset_full", full, 0);
        checkOutput("reset_pkt_done", pkt_done, 0);
        checkOutput("reset_pkt_drop", pkt_drop, 0);
        checkOutput("reset_overrun", overrun, 0);
        repeat (3) @(posedge clk);
        #1;
        n_rst     = 1'b1;
        monitorOn = 1'b1;
        idleCycles(2);

        $display("[TB] good packet");
        popPct = 0;
        pkt = '{8'hA5, 8'h3C, 8'h01};
        sendPacket(pkt, 1'b0);
        drain();

        $display("[TB] error packet");
        pkt = '{8'h11, 8'h22};
        sendPacket(pkt, 1'b1);
        drain();

        $display("[TB] overrun");
        pkt.delete();
        for (int i = 0; i < 10; i++) pkt.push_back(8'(i));
        sendPacket(pkt, 1'b0);
        drain();

        $display("[TB] write at full with simultaneous pop");
        pkt.delete();
        for (int i = 0; i < 8; i++) pkt.push_back(8'h80 + 8'(i));
        sendPacket(pkt, 1'b0);
        startPacket();
        forceRead = 1'b1;
        sendByte(8'h99);
        forceRead = 1'b0;
        endPacket(1'b0, 1'b0);
        drain();

        $display("[TB] wrap-around");
        pkt = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        sendPacket(pkt, 1'b0);
        drain();
        pkt = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
        sendPacket(pkt, 1'b0);
        drain();

        $display("[TB] back-to-back");
        startPacket();
        sendByte(8'hB0);
        sendByte(8'hB1);
        endPacket(1'b0, 1'b1);
        popPct = 50;
        sendByte(8'hC0);
        gapCycle();
        sendByte(8'hC1);
        endPacket(1'b0, 1'b0);
        popPct = 0;
        drain();

        $display("[TB] reset mid-packet");
        pkt = '{8'hD0, 8'hD1};
        sendPacket(pkt, 1'b0);
        startPacket();
        sendByte(8'hE0);
        sendByte(8'hE1);
        sendByte(8'hE2);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("rst_mid_empty", empty, 1);
        checkOutput("rst_mid_full", full, 0);
        checkOutput("rst_mid_pkt_done", pkt_done, 0);
        checkOutput("rst_mid_pkt_drop", pkt_drop, 0);
        checkOutput("rst_mid_overrun", overrun, 0);
        rcving       = 1'b0;
        w_enable     = 1'b0;
        r_enable     = 1'b0;
        r_error      = 1'b0;
        expQ.delete();
        pendQ.delete();
        modelOverrun = 1'b0;
        modelDone    = 1'b0;
        modelDrop    = 1'b0;
        tick();
        n_rst = 1'b1;
        idleCycles(1);
        pkt = '{8'h7E};
        sendPacket(pkt, 1'b0);
        drain();

        $display("[TB] randomized packets");
        inPkt = 1'b0;
        for (int p = 0; p < 40; p++) begin
            int len;
            bit nextRcv;
            popPct = $urandom_range(0, 60);
            if (!inPkt) startPacket();
            len = $urandom_range(0, 10);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) gapCycle();
                sendByte(8'($urandom));
            end
            nextRcv = ($urandom_range(0, 3) == 0);
            endPacket(($urandom_range(0, 3) == 0), nextRcv);
            inPkt = nextRcv;
            if (!inPkt) idleCycles($urandom_range(0, 3));
        end
        if (inPkt) endPacket(1'b0, 1'b0);
        popPct = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
